// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the pedal audio path: sample/slot sizes and the
// slot-tracking state encoding used by the transmitter, receiver and clock divider.
package i2s_pkg;

    localparam int I2S_WIDTH = 24;
    localparam int I2S_SLOT  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_e;

endpackage

// File: rtl/i2s_edge_det.sv
// Registers one mck-synchronous level and flags its rising/falling transitions.
// Pulses are suppressed while reset is high so release never reports a false edge.
module i2s_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic q;

    // Previous-cycle level; also tracks the live input during reset.
    always_ff @(posedge clk) begin
        q <= d;
    end

    assign rise = ~reset & d & ~q;
    assign fall = ~reset & ~d & q;

endmodule

// File: rtl/i2s_xmit.sv
// I2S transmitter: one-pair holding register behind valid/ready, frame-aligned
// load into per-channel shifters, MSB-first serialisation on bck falling edges.
module i2s_xmit
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH,
    parameter int SLOT  = I2S_SLOT,
    parameter int DELAY = 0
) (
    input  logic             mck,
    input  logic             reset,
    input  logic             bck,
    input  logic             lrck,
    input  logic [WIDTH-1:0] l_data,
    input  logic [WIDTH-1:0] r_data,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sdout,
    output logic             underrun,
    output logic             sync_err
);

    localparam int              CW        = $clog2(SLOT + 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(SLOT);
    localparam logic [WIDTH-1:0] ZERO_WORD = {WIDTH{1'b0}};
    localparam bit              DELAYED   = (DELAY != 0);

    logic             bck_fall;
    logic             bck_rise_unused;
    logic             lrck_rise;
    logic             lrck_fall;
    i2s_state_e       state;
    i2s_state_e       state_next;
    logic             start_left;
    logic             start_right;
    logic             bit_step;
    logic             sync_hit;
    logic             accept;
    logic             full;
    logic             full_next;
    logic [WIDTH-1:0] hold_l;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] load_l;
    logic [WIDTH-1:0] load_r;
    logic [WIDTH-1:0] l_sh;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    cnt;

    i2s_edge_det u_bck_edge (
        .clk   (mck),
        .reset (reset),
        .d     (bck),
        .rise  (bck_rise_unused),
        .fall  (bck_fall)
    );

    i2s_edge_det u_lrck_edge (
        .clk   (mck),
        .reset (reset),
        .d     (lrck),
        .rise  (lrck_rise),
        .fall  (lrck_fall)
    );

    // Slot state register.
    always_ff @(posedge mck) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Slot sequencing: lrck edges open slots and outrank a coincident bck fall.
    always_comb begin
        state_next  = state;
        start_left  = 1'b0;
        start_right = 1'b0;
        bit_step    = 1'b0;
        sync_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (lrck_fall) begin
                    state_next = LEFT;
                    start_left = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            LEFT, RIGHT: begin
                if (lrck_fall) begin
                    state_next = LEFT;
                    start_left = 1'b1;
                    sync_hit   = (cnt != CNT_MAX);
                end else if (lrck_rise) begin
                    state_next  = RIGHT;
                    start_right = 1'b1;
                    sync_hit    = (cnt != CNT_MAX);
                end else begin
                    bit_step = bck_fall;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding register occupancy; a frame load frees it before any new accept.
    always_comb begin
        accept = data_valid & data_ready;
        load_l = full ? hold_l : ZERO_WORD;
        load_r = full ? hold_r : ZERO_WORD;
        if (start_left && full) begin
            full_next = 1'b0;
        end else if (accept) begin
            full_next = 1'b1;
        end else begin
            full_next = full;
        end
    end

    // Holding register, shifters, bit counter and registered outputs.
    always_ff @(posedge mck) begin
        if (reset) begin
            hold_l     <= ZERO_WORD;
            hold_r     <= ZERO_WORD;
            full       <= 1'b0;
            data_ready <= 1'b1;
            l_sh       <= ZERO_WORD;
            r_sh       <= ZERO_WORD;
            cnt        <= {CW{1'b0}};
            sdout      <= 1'b0;
            underrun   <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            full       <= full_next;
            data_ready <= ~full_next;
            underrun   <= start_left & ~full;
            sync_err   <= sync_hit;
            if (accept) begin
                hold_l <= l_data;
                hold_r <= r_data;
            end
            if (start_left) begin
                cnt  <= CNT_ONE;
                r_sh <= load_r;
                if (DELAYED) begin
                    sdout <= 1'b0;
                    l_sh  <= load_l;
                end else begin
                    sdout <= load_l[WIDTH-1];
                    l_sh  <= {load_l[WIDTH-2:0], 1'b0};
                end
            end else if (start_right) begin
                cnt <= CNT_ONE;
                if (DELAYED) begin
                    sdout <= 1'b0;
                end else begin
                    sdout <= r_sh[WIDTH-1];
                    r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
                end
            end else if (bit_step) begin
                // Zeros shifted in cover the pad bits; a saturated counter holds 0.
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                    if (state == LEFT) begin
                        sdout <= l_sh[WIDTH-1];
                        l_sh  <= {l_sh[WIDTH-2:0], 1'b0};
                    end else begin
                        sdout <= r_sh[WIDTH-1];
                        r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    sdout <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_xmit.sv
// Directed bench for i2s_xmit: bck/lrck from a 10-bit mck counter, slot bits
// sampled mid-bck and compared against hand-computed words (DELAY 0 and 1).
module tb_i2s_xmit;

    logic        mck = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  cnt = 10'd0;
    logic        jump_req = 1'b0;
    logic [9:0]  jump_val = 10'd0;
    logic        bck;
    logic        lrck;
    logic [23:0] l_data = 24'd0;
    logic [23:0] r_data = 24'd0;
    logic        data_valid = 1'b0;
    logic        d0_ready, d0_sdout, d0_underrun, d0_sync_err;
    logic        d1_ready, d1_sdout, d1_underrun, d1_sync_err;

    int vecs = 0;
    int miss = 0;

    logic [31:0] cap_l0, cap_r0, cap_l1, cap_r1;
    logic        cap_und1, cap_und2, cap_rdy0, cap_rdy1, cap_rdy2, cap_se1, cap_se_r;

    assign bck  = cnt[3];
    assign lrck = cnt[9];

    always #5 mck = ~mck;

    // Frame counter; a one-cycle jump request forces an early lrck edge.
    always @(posedge mck) begin
        cnt <= jump_req ? jump_val : cnt + 10'd1;
    end

    i2s_xmit #(.WIDTH(24), .SLOT(32), .DELAY(0)) dut0 (
        .mck(mck), .reset(reset), .bck(bck), .lrck(lrck),
        .l_data(l_data), .r_data(r_data), .data_valid(data_valid),
        .data_ready(d0_ready), .sdout(d0_sdout), .underrun(d0_underrun), .sync_err(d0_sync_err)
    );

    i2s_xmit #(.WIDTH(24), .SLOT(32), .DELAY(1)) dut1 (
        .mck(mck), .reset(reset), .bck(bck), .lrck(lrck),
        .l_data(l_data), .r_data(r_data), .data_valid(data_valid),
        .data_ready(d1_ready), .sdout(d1_sdout), .underrun(d1_underrun), .sync_err(d1_sync_err)
    );

    task automatic wait_cnt(input logic [9:0] val);
        int guard;
        guard = 0;
        @(negedge mck);
        while (cnt !== val && guard < 2100) begin
            @(negedge mck);
            guard++;
        end
        if (cnt !== val) begin
            vecs++; miss++;
            $display("FAIL wait_cnt got %0d exp %0d", cnt, val);
        end
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        int guard;
        guard = 0;
        @(negedge mck);
        l_data = l; r_data = r; data_valid = 1'b1;
        while (d0_ready !== 1'b1 && guard < 3000) begin
            @(negedge mck);
            guard++;
        end
        if (d0_ready !== 1'b1) begin
            vecs++; miss++;
            $display("FAIL push_timeout ready %b exp 1", d0_ready);
        end
        @(negedge mck);
        data_valid = 1'b0;
    endtask

    // Captures one full frame from both instances, plus status around the load.
    task automatic capture_frame;
        wait_cnt(10'd0);
        cap_rdy0 = d0_ready;
        wait_cnt(10'd1);
        cap_und1 = d0_underrun; cap_rdy1 = d0_ready; cap_se1 = d0_sync_err;
        wait_cnt(10'd2);
        cap_und2 = d0_underrun; cap_rdy2 = d0_ready; data_valid = 1'b0;
        for (int n = 0; n < 32; n++) begin
            wait_cnt(10'(16 * n + 8));
            cap_l0 = {cap_l0[30:0], d0_sdout};
            cap_l1 = {cap_l1[30:0], d1_sdout};
        end
        wait_cnt(10'd513);
        cap_se_r = d0_sync_err;
        for (int n = 0; n < 32; n++) begin
            wait_cnt(10'(512 + 16 * n + 8));
            cap_r0 = {cap_r0[30:0], d0_sdout};
            cap_r1 = {cap_r1[30:0], d1_sdout};
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge mck);
        vecs++; if (d0_sdout !== 1'b0) begin miss++; $display("FAIL rst_sdout got %b exp 0", d0_sdout); end
        vecs++; if (d0_ready !== 1'b1) begin miss++; $display("FAIL rst_ready got %b exp 1", d0_ready); end
        vecs++; if (d0_underrun !== 1'b0) begin miss++; $display("FAIL rst_underrun got %b exp 0", d0_underrun); end
        vecs++; if (d0_sync_err !== 1'b0) begin miss++; $display("FAIL rst_sync_err got %b exp 0", d0_sync_err); end
        vecs++; if (d1_ready !== 1'b1) begin miss++; $display("FAIL rst_d1_ready got %b exp 1", d1_ready); end
        vecs++; if (d1_sdout !== 1'b0) begin miss++; $display("FAIL rst_d1_sdout got %b exp 0", d1_sdout); end
        reset = 1'b0;
        @(negedge mck);
        vecs++; if (d0_ready !== 1'b1) begin miss++; $display("FAIL rel_ready got %b exp 1", d0_ready); end
        vecs++; if (d0_sdout !== 1'b0) begin miss++; $display("FAIL rel_sdout got %b exp 0", d0_sdout); end
    endtask

    task automatic test_basic;
        push(24'hA5A5A5, 24'h3C3C3C);
        vecs++; if (d0_ready !== 1'b0) begin miss++; $display("FAIL t1_ready_drop got %b exp 0", d0_ready); end
        wait_cnt(10'd520);
        vecs++; if (d0_sdout !== 1'b0) begin miss++; $display("FAIL t1_idle_sdout got %b exp 0", d0_sdout); end
        capture_frame();
        vecs++; if (cap_l0 !== 32'hA5A5A500) begin miss++; $display("FAIL t1_left got %h exp a5a5a500", cap_l0); end
        vecs++; if (cap_r0 !== 32'h3C3C3C00) begin miss++; $display("FAIL t1_right got %h exp 3c3c3c00", cap_r0); end
        vecs++; if (cap_l1 !== 32'h52D2D280) begin miss++; $display("FAIL t1_d1_left got %h exp 52d2d280", cap_l1); end
        vecs++; if (cap_r1 !== 32'h1E1E1E00) begin miss++; $display("FAIL t1_d1_right got %h exp 1e1e1e00", cap_r1); end
        vecs++; if (cap_und1 !== 1'b0) begin miss++; $display("FAIL t1_underrun got %b exp 0", cap_und1); end
        vecs++; if (cap_se1 !== 1'b0) begin miss++; $display("FAIL t1_sync_left got %b exp 0", cap_se1); end
        vecs++; if (cap_se_r !== 1'b0) begin miss++; $display("FAIL t1_sync_right got %b exp 0", cap_se_r); end
        vecs++; if (cap_rdy1 !== 1'b1) begin miss++; $display("FAIL t1_ready_rise got %b exp 1", cap_rdy1); end
    endtask

    task automatic test_underrun;
        capture_frame();
        vecs++; if (cap_l0 !== 32'h0) begin miss++; $display("FAIL t2_left got %h exp 0", cap_l0); end
        vecs++; if (cap_r0 !== 32'h0) begin miss++; $display("FAIL t2_right got %h exp 0", cap_r0); end
        vecs++; if (cap_und1 !== 1'b1) begin miss++; $display("FAIL t2_underrun got %b exp 1", cap_und1); end
        vecs++; if (cap_und2 !== 1'b0) begin miss++; $display("FAIL t2_underrun_len got %b exp 0", cap_und2); end
        vecs++; if (d1_underrun !== 1'b0) begin miss++; $display("FAIL t2_d1_underrun got %b exp 0", d1_underrun); end
    endtask

    task automatic test_back_to_back;
        @(negedge mck);
        l_data = 24'h123456; r_data = 24'h89ABCD; data_valid = 1'b1;
        @(negedge mck);
        l_data = 24'hFEDCBA; r_data = 24'h000001;
        vecs++; if (d0_ready !== 1'b0) begin miss++; $display("FAIL t3_ready_drop got %b exp 0", d0_ready); end
        capture_frame();
        vecs++; if (cap_l0 !== 32'h12345600) begin miss++; $display("FAIL t3a_left got %h exp 12345600", cap_l0); end
        vecs++; if (cap_r0 !== 32'h89ABCD00) begin miss++; $display("FAIL t3a_right got %h exp 89abcd00", cap_r0); end
        vecs++; if (cap_rdy0 !== 1'b0) begin miss++; $display("FAIL t3a_ready_held got %b exp 0", cap_rdy0); end
        vecs++; if (cap_rdy1 !== 1'b1) begin miss++; $display("FAIL t3a_ready_rise got %b exp 1", cap_rdy1); end
        vecs++; if (cap_rdy2 !== 1'b0) begin miss++; $display("FAIL t3a_ready_take got %b exp 0", cap_rdy2); end
        vecs++; if (cap_und1 !== 1'b0) begin miss++; $display("FAIL t3a_underrun got %b exp 0", cap_und1); end
        capture_frame();
        vecs++; if (cap_l0 !== 32'hFEDCBA00) begin miss++; $display("FAIL t3b_left got %h exp fedcba00", cap_l0); end
        vecs++; if (cap_r0 !== 32'h00000100) begin miss++; $display("FAIL t3b_right got %h exp 00000100", cap_r0); end
        vecs++; if (cap_rdy2 !== 1'b1) begin miss++; $display("FAIL t3b_ready got %b exp 1", cap_rdy2); end
    endtask

    task automatic test_late_valid;
        wait_cnt(10'd0);
        l_data = 24'h800000; r_data = 24'h7FFFFF; data_valid = 1'b1;
        wait_cnt(10'd1);
        vecs++; if (d0_underrun !== 1'b1) begin miss++; $display("FAIL t4_underrun got %b exp 1", d0_underrun); end
        vecs++; if (d0_ready !== 1'b0) begin miss++; $display("FAIL t4_stored got %b exp 0", d0_ready); end
        data_valid = 1'b0;
        wait_cnt(10'd8);
        vecs++; if (d0_sdout !== 1'b0) begin miss++; $display("FAIL t4_no_bypass got %b exp 0", d0_sdout); end
        capture_frame();
        vecs++; if (cap_l0 !== 32'h80000000) begin miss++; $display("FAIL t4_left got %h exp 80000000", cap_l0); end
        vecs++; if (cap_r0 !== 32'h7FFFFF00) begin miss++; $display("FAIL t4_right got %h exp 7fffff00", cap_r0); end
        vecs++; if (cap_und1 !== 1'b0) begin miss++; $display("FAIL t4_next_underrun got %b exp 0", cap_und1); end
    endtask

    task automatic test_reset_mid;
        push(24'h000000, 24'hFFFFFF);
        wait_cnt(10'd2);
        push(24'h555555, 24'hAAAAAA);
        wait_cnt(10'd520);
        vecs++; if (d0_sdout !== 1'b1) begin miss++; $display("FAIL t5_pre_sdout got %b exp 1", d0_sdout); end
        wait_cnt(10'd600);
        reset = 1'b1;
        wait_cnt(10'd601);
        vecs++; if (d0_sdout !== 1'b0) begin miss++; $display("FAIL t5_rst_sdout got %b exp 0", d0_sdout); end
        vecs++; if (d0_ready !== 1'b1) begin miss++; $display("FAIL t5_rst_ready got %b exp 1", d0_ready); end
        reset = 1'b0;
        wait_cnt(10'd700);
        vecs++; if (d0_sdout !== 1'b0) begin miss++; $display("FAIL t5_hold_sdout got %b exp 0", d0_sdout); end
        capture_frame();
        vecs++; if (cap_l0 !== 32'h0) begin miss++; $display("FAIL t5_left got %h exp 0", cap_l0); end
        vecs++; if (cap_r0 !== 32'h0) begin miss++; $display("FAIL t5_right got %h exp 0", cap_r0); end
        vecs++; if (cap_und1 !== 1'b1) begin miss++; $display("FAIL t5_underrun got %b exp 1", cap_und1); end
        vecs++; if (cap_se1 !== 1'b0) begin miss++; $display("FAIL t5_sync got %b exp 0", cap_se1); end
    endtask

    task automatic test_sync_err;
        push(24'hC00003, 24'h800000);
        wait_cnt(10'd8);
        vecs++; if (d0_sdout !== 1'b1) begin miss++; $display("FAIL t6_left_msb got %b exp 1", d0_sdout); end
        wait_cnt(10'd335);
        jump_val = 10'd512; jump_req = 1'b1;
        wait_cnt(10'd512);
        jump_req = 1'b0;
        wait_cnt(10'd513);
        vecs++; if (d0_sync_err !== 1'b1) begin miss++; $display("FAIL t6_sync_err got %b exp 1", d0_sync_err); end
        vecs++; if (d1_sync_err !== 1'b1) begin miss++; $display("FAIL t6_d1_sync_err got %b exp 1", d1_sync_err); end
        vecs++; if (d0_sdout !== 1'b1) begin miss++; $display("FAIL t6_right_msb got %b exp 1", d0_sdout); end
        vecs++; if (d1_sdout !== 1'b0) begin miss++; $display("FAIL t6_d1_delay got %b exp 0", d1_sdout); end
        wait_cnt(10'd514);
        vecs++; if (d0_sync_err !== 1'b0) begin miss++; $display("FAIL t6_sync_len got %b exp 0", d0_sync_err); end
        wait_cnt(10'd529);
        vecs++; if (d0_sdout !== 1'b0) begin miss++; $display("FAIL t6_right_bit1 got %b exp 0", d0_sdout); end
        vecs++; if (d1_sdout !== 1'b1) begin miss++; $display("FAIL t6_d1_msb got %b exp 1", d1_sdout); end
        wait_cnt(10'd0);
        wait_cnt(10'd1);
        vecs++; if (d0_sync_err !== 1'b0) begin miss++; $display("FAIL t6_resync got %b exp 0", d0_sync_err); end
        vecs++; if (d0_underrun !== 1'b1) begin miss++; $display("FAIL t6_underrun got %b exp 1", d0_underrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_late_valid();
        test_reset_mid();
        test_sync_err();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
